// File: rtl/regfile_pkg.sv
// Shared parameter defaults and the write-port arbitration helper for regfile_mp.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 4;
  localparam int NUM_WR_DEF = 2;
  localparam int MAX_WR     = 16;

  // Highest-index asserted hit wins; -1 means no port targets the address.
  function automatic int win_port(input logic [MAX_WR-1:0] hits);
    int w;
    w = -1;
    for (int j = 0; j < MAX_WR; j++) begin
      w = hits[j] ? j : w;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: reservation sets, writeback clears, read ports look them up.
// REGFILE_BYPASS_EN makes read ports report the post-edge busy value.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rsv_en,
  input  logic [$clog2(DEPTH)-1:0]          rsv_addr,
  input  logic [DEPTH-1:0]                  wr_hit,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NUM_RD-1:0]                 rd_busy
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;

  // Set beats clear: a reservation alongside a writeback means a new producer is in flight.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < DEPTH; r++) begin
      if ((ZERO_REG != 0) && (r == 0)) begin
        busy_nxt_s[r] = 1'b0;
      end else if (rsv_en && (rsv_addr == AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Busy flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Per-port busy lookup, forced low while in reset.
  always_comb begin
    logic [AW-1:0] ra;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (!rst_n) begin
        rd_busy[i] = 1'b0;
      end else begin
`ifdef REGFILE_BYPASS_EN
        rd_busy[i] = busy_nxt_s[ra];
`else
        rd_busy[i] = busy_r[ra];
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and optional zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]          rd_data,
  output logic [NUM_RD-1:0]                 rd_busy,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR*$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]          wr_data,
  input  logic                              rsv_en,
  input  logic [$clog2(DEPTH)-1:0]          rsv_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r    [DEPTH];
  logic [DATA_W-1:0] wr_val_s [DEPTH];
  logic [DEPTH-1:0]  wr_hit_s;

  // Resolve, per register, whether any port writes it and which port's data wins.
  always_comb begin
    logic [MAX_WR-1:0] hv;
    int                w;
    wr_hit_s = '0;
    hv       = '0;
    w        = -1;
    for (int r = 0; r < DEPTH; r++) begin
      hv = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        hv[j] = wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r));
      end
      w = win_port(hv);
      if ((w >= 0) && !((ZERO_REG != 0) && (r == 0))) begin
        wr_hit_s[r] = 1'b1;
        wr_val_s[r] = wr_data[w*DATA_W +: DATA_W];
      end else begin
        wr_hit_s[r] = 1'b0;
        wr_val_s[r] = '0;
      end
    end
  end

  // Data array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit_s[r]) begin
          mem_r[r] <= wr_val_s[r];
        end
      end
    end
  end

  // Read muxes; reset and the zero register override any forwarded value.
  always_comb begin
    logic [AW-1:0] ra;
    rd_data = '0;
    ra      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (!rst_n) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_hit_s[ra]) begin
        rd_data[i*DATA_W +: DATA_W] = wr_val_s[ra];
`endif
      end else begin
        rd_data[i*DATA_W +: DATA_W] = mem_r[ra];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_hit   (wr_hit_s),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with a per-register busy scoreboard, the successor to the fixed 4-read/2-write, 32×32 integer register file in the MIPS datapath. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports with deterministic write-conflict priority. It optionally hardwires entry 0 to zero. Busy bits are set by issue-stage reservations and cleared by writeback, so the decode stage can detect RAW hazards directly from the read ports.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (≥2, power of two); AW = $clog2(DEPTH)
- NUM_RD, 4, number of read ports (≥1)
- NUM_WR, 2, number of write ports (≥1)
- ZERO_REG, 1, 1 = entry 0 reads zero, ignores writes and reservations, and is never busy
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy bit of the addressed register for each port
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  reserve the register at rsv_addr (set its busy bit)
- rsv_addr  in  AW  reservation address

## Operation
- Reset (rst_n=0, asynchronous): all registers clear to 0 and all busy bits clear. While reset is asserted, rd_data=0 and rd_busy=0 on every port.
- Write: on a clk rising edge with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
- Write conflict: when several enabled ports target the same address, the highest-index port wins. The other ports' data is discarded.
- Busy update per register r at each edge: set if rsv_en and rsv_addr==r; else cleared if any wr_en[j] targets r; else held.
  - Reservation and write to the same r in the same cycle: the data is written and busy stays set, because a new producer is in flight.
  - A write to a non-busy register is legal. Busy stays 0.
- ZERO_REG=1: writes and reservations to address 0 have no effect. Reads of address 0 return data 0 and busy 0, regardless of bypass.
- Reads are combinational from the stored state, subject to the bypass rules in Configuration.
- Address ≥ DEPTH cannot occur, because DEPTH is a power of two.

## Timing
- Write-to-storage latency: 1 edge. Reservation-to-busy latency: 1 edge.
- Without bypass, a read in the write cycle returns the old value; the new value is visible from the following cycle.
- Reset may assert mid-operation. It takes effect immediately and discards in-flight writes and reservations. The first write is accepted on the first edge after rst_n deasserts.
- All outputs are purely combinational from the state and inputs. No read latency.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rd_data for an address being written this cycle returns the winning port's wr_data, using the same highest-index priority.
  - rd_busy returns the post-edge busy value. A same-cycle write clears it unless a same-cycle reservation targets that address.
  - The ZERO_REG rules still apply.
- REGFILE_BYPASS_EN undefined: reads reflect stored state only. The write path is identical in both cases.

## Structure
- Package regfile_pkg holds:
  - default parameter constants (DATA_W_DEF, DEPTH_DEF, NUM_RD_DEF, NUM_WR_DEF)
  - a function that resolves the winning write port for a given address.
- Sub-module regfile_scoreboard holds the DEPTH busy flops, the set/clear priority logic and the per-read-port busy lookup. The top module holds the data array, write arbitration and the read/bypass muxes.

## Test plan
- Reset: after reset, write reg5=0xDEAD_BEEF. Assert rst_n=0 mid-cycle → rd_data for reg5 reads 0 immediately and rd_busy=0.
- Dual write conflict: wr_en=2'b11, both ports address 7, data 0x11 on port 0 and 0x22 on port 1 → next cycle reg7 reads 0x22.
- Zero register: write 0xFFFF_FFFF to reg0 and rsv_en with rsv_addr=0 → reg0 reads 0 with busy 0. With ZERO_REG=0, the next cycle reads 0xFFFF_FFFF and busy=1.
- Scoreboard: rsv reg9 → busy=1 next cycle. Write reg9=0x1234 → busy=0 next cycle. Simultaneous rsv and write to reg9 → data 0x1234 stored and busy=1.
- Bypass, with REGFILE_BYPASS_EN: write reg3=0xA5A5 while reading reg3 in the same cycle → rd_data=0xA5A5 in that cycle and rd_busy=0. Without the macro, the old value is returned that cycle and 0xA5A5 the next.
- Parameter sweep with DATA_W=64, DEPTH=64, NUM_RD=6, NUM_WR=3: random writes checked against a reference model over 10k cycles, with all read ports consistent.
